// File: rtl/mfp_ahb_lite_eic_pri_pkg.sv
// Shared constants for the prioritised EIC: register word offsets, the AHB IDLE
// encoding and the parameter legality check.
package mfp_ahb_lite_eic_pri_pkg;

    typedef logic [5:0] reg_word_t;

    localparam reg_word_t  REG_PENDING   = 6'd0;
    localparam reg_word_t  REG_MASK      = 6'd1;
    localparam reg_word_t  REG_SENSE     = 6'd2;
    localparam reg_word_t  REG_POLARITY  = 6'd3;
    localparam reg_word_t  REG_PRIO_BASE = 6'd4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;

    function automatic bit params_legal(input int channels, input int prio_width);
        return (channels >= 1) && (channels <= 32) && (prio_width >= 1) && (prio_width <= 6);
    endfunction

endpackage

// File: rtl/mfp_eic_pri_arbiter.sv
// Binary reduction tree picking the highest priority; on a tie the left (lower
// index) subtree wins, so equal priorities resolve to the lowest channel.
module mfp_eic_pri_arbiter #(
    parameter int CHANNELS   = 16,
    parameter int PRIO_WIDTH = 3
) (
    input  logic [CHANNELS-1:0][PRIO_WIDTH-1:0] i_prio,
    output logic [PRIO_WIDTH-1:0]               o_prio,
    output logic [5:0]                          o_index
);

    localparam int LEAVES = 1 << $clog2(CHANNELS);

    // Heap layout: node n has children 2n and 2n+1, root at 1, leaves from LEAVES.
    logic [PRIO_WIDTH-1:0] w_node_prio [2*LEAVES];
    logic [5:0]            w_node_idx  [2*LEAVES];

    always_comb begin
        for (int n = 0; n < 2*LEAVES; n++) begin
            w_node_prio[n] = '0;
            w_node_idx[n]  = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            w_node_prio[LEAVES+i] = i_prio[i];
            w_node_idx[LEAVES+i]  = 6'(i);
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            if (w_node_prio[2*n+1] > w_node_prio[2*n]) begin
                w_node_prio[n] = w_node_prio[2*n+1];
                w_node_idx[n]  = w_node_idx[2*n+1];
            end else begin
                w_node_prio[n] = w_node_prio[2*n];
                w_node_idx[n]  = w_node_idx[2*n];
            end
        end
    end

    assign o_prio  = w_node_prio[1];
    assign o_index = w_node_idx[1];

endmodule

// File: rtl/mfp_ahb_lite_eic_pri.sv
// Prioritised external interrupt controller for MIPSfpga+: AHB-Lite register
// front end, input synchronisers, pending logic and registered EIC outputs.
module mfp_ahb_lite_eic_pri
    import mfp_ahb_lite_eic_pri_pkg::*;
#(
    parameter int CHANNELS   = 16,
    parameter int PRIO_WIDTH = 3
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [31:0]         HADDR,
    input  logic                HSEL,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HBURST,
    input  logic [2:0]          HSIZE,
    input  logic [3:0]          HPROT,
    input  logic                HMASTLOCK,
    input  logic                SI_Endian,
    input  logic [31:0]         HWDATA,
    output logic [31:0]         HRDATA,
    output logic                HREADY,
    output logic                HRESP,
    input  logic [CHANNELS-1:0] EIC_input,
    output logic [7:0]          EIC_Interrupt,
    output logic [5:0]          EIC_Vector,
    output logic [16:0]         EIC_Offset,
    output logic [3:0]          EIC_ShadowSet,
    output logic                EIC_Present,
    input  logic                EIC_IAck,
    input  logic [5:0]          EIC_IVN,
    input  logic [7:0]          EIC_IPL,
    input  logic [16:0]         EIC_ION
);

    if (!params_legal(CHANNELS, PRIO_WIDTH)) begin : g_param_check
        $error("mfp_ahb_lite_eic_pri: CHANNELS must be 1..32 and PRIO_WIDTH 1..6");
    end

    logic                               r_valid, r_write;
    reg_word_t                          r_word;
    logic [CHANNELS-1:0]                r_sync1, r_sync2, r_hist;
    logic [CHANNELS-1:0]                r_pending, r_mask, r_sense, r_pol;
    logic [CHANNELS-1:0][PRIO_WIDTH-1:0] r_prio;
    logic [7:0]                         r_irq;
    logic [5:0]                         r_vec;

    logic                               w_wr;
    logic [CHANNELS-1:0]                w_act, w_act_prev, w_rise, w_clr;
    logic [CHANNELS-1:0][PRIO_WIDTH-1:0] w_cand_prio;
    logic [PRIO_WIDTH-1:0]              w_win_prio;
    logic [5:0]                         w_win_idx;
    logic [31:0]                        w_rdata;
    logic                               w_unused;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_word  <= '0;
        end else begin
            r_valid <= HSEL && (HTRANS != HTRANS_IDLE);
            r_write <= HWRITE;
            r_word  <= HADDR[7:2];
        end
    end

    assign w_wr = r_valid && r_write;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mask  <= '0;
            r_sense <= '0;
            r_pol   <= '0;
            r_prio  <= '0;
        end else if (w_wr) begin
            if (r_word == REG_MASK)     r_mask  <= HWDATA[CHANNELS-1:0];
            if (r_word == REG_SENSE)    r_sense <= HWDATA[CHANNELS-1:0];
            if (r_word == REG_POLARITY) r_pol   <= HWDATA[CHANNELS-1:0];
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_word == REG_PRIO_BASE + 6'(i)) r_prio[i] <= HWDATA[PRIO_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= EIC_input;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Previous activity uses the current polarity so a polarity write alone never fakes an edge.
    assign w_act      = ~(r_sync2 ^ r_pol);
    assign w_act_prev = ~(r_hist ^ r_pol);
    assign w_rise     = w_act & ~w_act_prev;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_clr[i] = (w_wr && (r_word == REG_PENDING) && HWDATA[i]) ||
                       (EIC_IAck && (EIC_IVN == 6'(i)));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_sense[i]) begin
                    if (w_rise[i])     r_pending[i] <= 1'b1;
                    else if (w_clr[i]) r_pending[i] <= 1'b0;
                end else begin
                    r_pending[i] <= w_act[i];
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (r_valid && !r_write) begin
            case (r_word)
                REG_PENDING:  w_rdata[CHANNELS-1:0] = r_pending;
                REG_MASK:     w_rdata[CHANNELS-1:0] = r_mask;
                REG_SENSE:    w_rdata[CHANNELS-1:0] = r_sense;
                REG_POLARITY: w_rdata[CHANNELS-1:0] = r_pol;
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (r_word == REG_PRIO_BASE + 6'(i)) w_rdata[PRIO_WIDTH-1:0] = r_prio[i];
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_cand_prio = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cand_prio[i] = (r_pending[i] && r_mask[i]) ? r_prio[i] : '0;
        end
    end

    mfp_eic_pri_arbiter #(
        .CHANNELS   (CHANNELS),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_arbiter (
        .i_prio  (w_cand_prio),
        .o_prio  (w_win_prio),
        .o_index (w_win_idx)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq <= '0;
            r_vec <= '0;
        end else if (w_win_prio != '0) begin
            r_irq <= 8'(w_win_prio);
            r_vec <= w_win_idx;
        end else begin
            r_irq <= '0;
        end
    end

    assign HRDATA        = w_rdata;
    assign HREADY        = 1'b1;
    assign HRESP         = 1'b0;
    assign EIC_Interrupt = r_irq;
    assign EIC_Vector    = r_vec;
    assign EIC_Offset    = '0;
    assign EIC_ShadowSet = '0;
    assign EIC_Present   = 1'b1;

    assign w_unused = ^{HADDR[31:8], HADDR[1:0], HBURST, HSIZE, HPROT, HMASTLOCK,
                        SI_Endian, HWDATA, EIC_IPL, EIC_ION};

endmodule

// File: tb/tb_mfp_ahb_lite_eic_pri.sv
// Self-checking bench for mfp_ahb_lite_eic_pri: register table, read scoreboard
// and hand-written sequences for edge/level/priority/collision/reset cases.
module tb_mfp_ahb_lite_eic_pri;

    localparam int CHANNELS   = 16;
    localparam int PRIO_WIDTH = 3;

    logic                HCLK, HRESETn;
    logic [31:0]         HADDR, HWDATA, HRDATA;
    logic                HSEL, HWRITE, HMASTLOCK, SI_Endian, HREADY, HRESP;
    logic [1:0]          HTRANS;
    logic [2:0]          HBURST, HSIZE;
    logic [3:0]          HPROT;
    logic [CHANNELS-1:0] EIC_input;
    logic [7:0]          EIC_Interrupt, EIC_IPL;
    logic [5:0]          EIC_Vector, EIC_IVN;
    logic [16:0]         EIC_Offset, EIC_ION;
    logic [3:0]          EIC_ShadowSet;
    logic                EIC_Present, EIC_IAck;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;
    vec_t vecs[12];

    mfp_ahb_lite_eic_pri #(.CHANNELS(CHANNELS), .PRIO_WIDTH(PRIO_WIDTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .SI_Endian(SI_Endian), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .EIC_input(EIC_input),
        .EIC_Interrupt(EIC_Interrupt), .EIC_Vector(EIC_Vector), .EIC_Offset(EIC_Offset),
        .EIC_ShadowSet(EIC_ShadowSet), .EIC_Present(EIC_Present), .EIC_IAck(EIC_IAck),
        .EIC_IVN(EIC_IVN), .EIC_IPL(EIC_IPL), .EIC_ION(EIC_ION)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: read data 0x%08h with no expectation queued", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // All bus tasks start and end at posedge+1.
    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        sb_pop(HRDATA);
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_wr_rd(input logic [31:0] aw, input logic [31:0] d,
                             input logic [31:0] ar, input logic [31:0] exp, input string name);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = aw;
        @(posedge HCLK); #1;
        sb_q.push_back(e);
        HWDATA = d; HWRITE = 1'b0; HADDR = ar;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        sb_pop(HRDATA);
        @(posedge HCLK); #1;
    endtask

    initial begin
        vecs[0]  = '{"tbl_mask_all",   32'h04, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[1]  = '{"tbl_sense",      32'h08, 32'h1234_5678, 32'h0000_5678};
        vecs[2]  = '{"tbl_pol",        32'h0C, 32'hDEAD_BEEF, 32'h0000_BEEF};
        vecs[3]  = '{"tbl_prio0_trunc",32'h10, 32'h0000_00FF, 32'h0000_0007};
        vecs[4]  = '{"tbl_prio15",     32'h4C, 32'h0000_0005, 32'h0000_0005};
        vecs[5]  = '{"tbl_prio16_unm", 32'h50, 32'h0000_0007, 32'h0000_0000};
        vecs[6]  = '{"tbl_addr_fc",    32'hFC, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{"tbl_mask_clr",   32'h04, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{"tbl_sense_clr",  32'h08, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{"tbl_pol_clr",    32'h0C, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{"tbl_prio0_clr",  32'h10, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{"tbl_prio15_clr", 32'h4C, 32'h0000_0000, 32'h0000_0000};

        HRESETn = 1'b0; HADDR = '0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HBURST = '0; HSIZE = 3'b010; HPROT = '0; HMASTLOCK = 1'b0; SI_Endian = 1'b0;
        HWDATA = '0; EIC_input = '1; EIC_IAck = 1'b0; EIC_IVN = '0; EIC_IPL = '0; EIC_ION = '0;
        cycles(3);
        HRESETn = 1'b1;
        cycles(5);

        check("rst_interrupt", 32'(EIC_Interrupt), 32'h0);
        check("rst_vector",    32'(EIC_Vector), 32'h0);
        check("rst_present",   32'(EIC_Present), 32'h1);
        check("rst_hready",    32'(HREADY), 32'h1);
        check("rst_hresp",     32'(HRESP), 32'h0);
        check("rst_consts",    32'({EIC_Offset, EIC_ShadowSet}), 32'h0);
        ahb_read_chk(32'h00, 32'h0, "rst_pending");
        ahb_read_chk(32'h04, 32'h0, "rst_mask");
        ahb_read_chk(32'h08, 32'h0, "rst_sense");
        ahb_read_chk(32'h0C, 32'h0, "rst_pol");
        ahb_read_chk(32'h10, 32'h0, "rst_prio0");
        ahb_read_chk(32'h4C, 32'h0, "rst_prio15");

        foreach (vecs[v]) begin
            ahb_write(vecs[v].addr, vecs[v].wdata);
            ahb_read_chk(vecs[v].addr, vecs[v].rexp, vecs[v].name);
        end
        cycles(3);

        // Edge channel 3, rising.
        EIC_input[3] = 1'b0;
        cycles(3);
        ahb_write(32'h0C, 32'h8);
        ahb_write(32'h08, 32'h8);
        ahb_write(32'h1C, 32'h5);
        ahb_write(32'h04, 32'h8);
        cycles(2);
        ahb_read_chk(32'h00, 32'h0, "edge_pending_idle");
        EIC_input[3] = 1'b1;
        @(posedge HCLK); #1;
        EIC_input[3] = 1'b0;
        cycles(2);
        check("edge_irq_k2", 32'(EIC_Interrupt), 32'h0);
        cycles(1);
        check("edge_irq_k3", 32'(EIC_Interrupt), 32'h5);
        check("edge_vec_k3", 32'(EIC_Vector), 32'h3);
        ahb_read_chk(32'h00, 32'h8, "edge_pending_held");
        EIC_IAck = 1'b1; EIC_IVN = 6'd3;
        @(posedge HCLK); #1;
        EIC_IAck = 1'b0;
        check("iack_irq_same", 32'(EIC_Interrupt), 32'h5);
        cycles(1);
        check("iack_irq_next", 32'(EIC_Interrupt), 32'h0);
        check("iack_vec_hold", 32'(EIC_Vector), 32'h3);
        ahb_read_chk(32'h00, 32'h0, "iack_pending");
        ahb_write(32'h04, 32'h0);
        ahb_write(32'h1C, 32'h0);
        ahb_write(32'h08, 32'h0);
        EIC_input[3] = 1'b1;
        ahb_write(32'h0C, 32'h0);
        cycles(3);

        // Level channels 2 and 7, active-high, priority and ties.
        ahb_write(32'h0C, 32'h84);
        ahb_write(32'h18, 32'h4);
        ahb_write(32'h2C, 32'h6);
        ahb_write(32'h04, 32'h84);
        cycles(2);
        check("prio_irq", 32'(EIC_Interrupt), 32'h6);
        check("prio_vec", 32'(EIC_Vector), 32'h7);
        ahb_write(32'h18, 32'h6);
        check("tie_vec_before", 32'(EIC_Vector), 32'h7);
        cycles(1);
        check("tie_vec_after", 32'(EIC_Vector), 32'h2);
        check("tie_irq", 32'(EIC_Interrupt), 32'h6);
        ahb_write(32'h04, 32'h0);
        ahb_write(32'h18, 32'h0);
        ahb_write(32'h2C, 32'h0);
        ahb_write(32'h0C, 32'h0);
        cycles(3);

        // Level channel 1, active-low.
        ahb_write(32'h14, 32'h2);
        ahb_write(32'h04, 32'h2);
        EIC_input[1] = 1'b0;
        cycles(5);
        check("lvl_irq", 32'(EIC_Interrupt), 32'h2);
        check("lvl_vec", 32'(EIC_Vector), 32'h1);
        ahb_read_chk(32'h00, 32'h2, "lvl_pending");
        ahb_write(32'h00, 32'h2);
        ahb_read_chk(32'h00, 32'h2, "lvl_w1c_ignored");
        EIC_input[1] = 1'b1;
        cycles(3);
        check("lvl_irq_k2", 32'(EIC_Interrupt), 32'h2);
        cycles(1);
        check("lvl_irq_k3", 32'(EIC_Interrupt), 32'h0);
        ahb_write(32'h04, 32'h0);
        ahb_write(32'h14, 32'h0);

        // Rising edge on channel 0 lands on the same edge as a W1C of bit 0.
        EIC_input[0] = 1'b0;
        cycles(3);
        ahb_write(32'h0C, 32'h1);
        ahb_write(32'h08, 32'h1);
        cycles(2);
        ahb_read_chk(32'h00, 32'h0, "coll_pending_idle");
        EIC_input[0] = 1'b1;
        @(posedge HCLK); #1;
        ahb_write(32'h00, 32'h1);
        ahb_read_chk(32'h00, 32'h1, "coll_set_wins");
        ahb_write(32'h00, 32'h1);
        ahb_read_chk(32'h00, 32'h0, "coll_w1c_alone");

        // Bus corner cases and reset mid-transfer.
        ahb_wr_rd(32'h04, 32'hA5A5, 32'h04, 32'hA5A5, "b2b_mask");
        ahb_write(32'h0C, 32'h21);
        ahb_write(32'h24, 32'h4);
        cycles(3);
        check("pre_rst_irq", 32'(EIC_Interrupt), 32'h4);
        check("pre_rst_vec", 32'(EIC_Vector), 32'h5);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFFFF;
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_irq", 32'(EIC_Interrupt), 32'h0);
        check("midrst_vec", 32'(EIC_Vector), 32'h0);
        check("midrst_hrdata", HRDATA, 32'h0);
        cycles(2);
        HRESETn = 1'b1;
        cycles(5);
        ahb_read_chk(32'h04, 32'h0, "postrst_mask");
        ahb_read_chk(32'h24, 32'h0, "postrst_prio5");
        check("end_irq", 32'(EIC_Interrupt), 32'h0);
        check("end_hready", 32'(HREADY), 32'h1);
        check("end_present", 32'(EIC_Present), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
